// File: rtl/fifo_access_ctrl_if.sv
// rtl/fifo_access_ctrl_if.sv - client and FIFO-side signal bundle for fifo_access_ctrl
//
// Ports (via modports):
//   slave  : controller view. It takes the requests, write data and FIFO
//            status/read data, and drives the grants, read return, FIFO
//            enables/data_in, occupancy and sync_err.
//   master : environment view, with the opposite directions.
interface fifo_access_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
);
  logic             wr0_req;
  logic [WIDTH-1:0] wr0_data;
  logic             wr0_gnt;
  logic             wr1_req;
  logic [WIDTH-1:0] wr1_data;
  logic             wr1_gnt;
  logic             rd_req;
  logic             rd_gnt;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             fifo_wr_en;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data_in;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] occupancy;
  logic             sync_err;

  modport slave (
    input  wr0_req, wr0_data, wr1_req, wr1_data, rd_req,
           fifo_data_out, fifo_empty, fifo_full,
    output wr0_gnt, wr1_gnt, rd_gnt, rd_valid, rd_data,
           fifo_wr_en, fifo_rd_en, fifo_data_in, occupancy, sync_err
  );

  modport master (
    output wr0_req, wr0_data, wr1_req, wr1_data, rd_req,
           fifo_data_out, fifo_empty, fifo_full,
    input  wr0_gnt, wr1_gnt, rd_gnt, rd_valid, rd_data,
           fifo_wr_en, fifo_rd_en, fifo_data_in, occupancy, sync_err
  );
endinterface

// File: rtl/fifo_access_ctrl.sv
// rtl/fifo_access_ctrl.sv - shares one FIFO between two writers and one reader
//
// Ports:
//   clk  : rising-edge clock
//   rstN : asynchronous active-low reset
//   bus  : fifo_access_ctrl_if.slave. It carries the wr0/wr1/rd handshakes,
//          the FIFO enables and data, the occupancy count and the sticky
//          sync_err flag.
module fifo_access_ctrl #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input logic                clk,
  input logic                rstN,
  fifo_access_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ZERO_C  = '0;
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t                state_q, state_d;
  logic                  rr_ptr_q, rr_ptr_d;     // write port that wins a tie
  logic                  last_op_q, last_op_d;   // 1 = last op was WR, 0 = RD
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic                  sync_err_q, sync_err_d;
  logic                  wr0_gnt_q, wr0_gnt_d;
  logic                  wr1_gnt_q, wr1_gnt_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [FIFO_WIDTH-1:0] data_in_q, data_in_d;
  logic [FIFO_WIDTH-1:0] rd_hold_q, rd_hold_d;

  logic wr0_eff, wr1_eff, wr_ok, rd_ok, wr_port;

  always_comb begin
    state_d    = S_IDLE;
    rr_ptr_d   = rr_ptr_q;
    last_op_d  = last_op_q;
    occ_d      = occ_q;
    wr0_gnt_d  = 1'b0;
    wr1_gnt_d  = 1'b0;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    data_in_d  = '0;
    rd_valid_d = (state_q == S_RD);
    rd_hold_d  = rd_valid_q ? bus.fifo_data_out : rd_hold_q;

    // Count after the op currently on the FIFO pins; the FIFO flags only
    // catch up next cycle, so this guards back-to-back over/underflow.
    if (state_q == S_WR && occ_q != DEPTH_C) begin
      occ_d = occ_q + ONE_C;
    end else if (state_q == S_RD && occ_q != ZERO_C) begin
      occ_d = occ_q - ONE_C;
    end

    // A request still high in its own gnt cycle is the one just consumed.
    wr0_eff = bus.wr0_req & ~wr0_gnt_q;
    wr1_eff = bus.wr1_req & ~wr1_gnt_q;
    wr_ok   = (wr0_eff | wr1_eff) & ~bus.fifo_full & (occ_d < DEPTH_C);
    rd_ok   = bus.rd_req & ~bus.fifo_empty & (occ_d > ZERO_C) & (state_q != S_RD);
    wr_port = (wr0_eff & wr1_eff) ? rr_ptr_q : wr1_eff;

    if (wr_ok && rd_ok) begin
      state_d = last_op_q ? S_RD : S_WR;
    end else if (wr_ok) begin
      state_d = S_WR;
    end else if (rd_ok) begin
      state_d = S_RD;
    end

    case (state_d)
      S_WR: begin
        wr_en_d   = 1'b1;
        last_op_d = 1'b1;
        rr_ptr_d  = ~wr_port;
        if (wr_port) begin
          wr1_gnt_d = 1'b1;
          data_in_d = bus.wr1_data;
        end else begin
          wr0_gnt_d = 1'b1;
          data_in_d = bus.wr0_data;
        end
      end
      S_RD: begin
        rd_en_d   = 1'b1;
        last_op_d = 1'b0;
      end
      default: ;
    endcase

    sync_err_d = sync_err_q
               | ((occ_q == DEPTH_C) != bus.fifo_full)
               | ((occ_q == ZERO_C)  != bus.fifo_empty);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= 1'b0;
      last_op_q  <= 1'b0;
      occ_q      <= '0;
      sync_err_q <= 1'b0;
      wr0_gnt_q  <= 1'b0;
      wr1_gnt_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      data_in_q  <= '0;
      rd_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      last_op_q  <= last_op_d;
      occ_q      <= occ_d;
      sync_err_q <= sync_err_d;
      wr0_gnt_q  <= wr0_gnt_d;
      wr1_gnt_q  <= wr1_gnt_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      rd_valid_q <= rd_valid_d;
      data_in_q  <= data_in_d;
      rd_hold_q  <= rd_hold_d;
    end
  end

  assign bus.wr0_gnt      = wr0_gnt_q;
  assign bus.wr1_gnt      = wr1_gnt_q;
  assign bus.rd_gnt       = rd_en_q;
  assign bus.rd_valid     = rd_valid_q;
  // The FIFO output is registered and only valid in the rd_valid cycle, so
  // it is passed straight through then and held afterwards.
  assign bus.rd_data      = rd_valid_q ? bus.fifo_data_out : rd_hold_q;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_rd_en   = rd_en_q;
  assign bus.fifo_data_in = data_in_q;
  assign bus.occupancy    = occ_q;
  assign bus.sync_err     = sync_err_q;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// tb/tb_fifo_access_ctrl.sv - directed self-checking bench for fifo_access_ctrl
module tb_fifo_access_ctrl;
  localparam int W = 32;
  localparam int D = 4;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic force_full = 1'b0;
  int total = 0;
  int bad = 0;

  fifo_access_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  fifo_access_ctrl #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Simple FIFO model: registered read data, flags from its own count.
  logic [W-1:0] mem [D];
  logic [W-1:0] dout;
  int           cnt;
  logic [1:0]   wp, rp;
  logic         do_wr, do_rd;

  assign do_wr = bus.fifo_wr_en && (cnt < D);
  assign do_rd = bus.fifo_rd_en && (cnt > 0);

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt  <= 0;
      wp   <= '0;
      rp   <= '0;
      dout <= '0;
    end else begin
      if (do_wr) begin
        mem[wp] <= bus.fifo_data_in;
        wp      <= wp + 2'd1;
      end
      if (do_rd) begin
        dout <= mem[rp];
        rp   <= rp + 2'd1;
      end
      cnt <= cnt + (do_wr ? 1 : 0) - (do_rd ? 1 : 0);
    end
  end

  assign bus.fifo_data_out = dout;
  assign bus.fifo_empty    = (cnt == 0);
  assign bus.fifo_full     = (cnt == D) || force_full;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.wr0_req  = 1'b0;
    bus.wr0_data = '0;
    bus.wr1_req  = 1'b0;
    bus.wr1_data = '0;
    bus.rd_req   = 1'b0;
    force_full   = 1'b0;
  endtask

  task automatic reset_dut();
    rstN = 1'b0;
    clear_inputs();
    tick();
    tick();
    rstN = 1'b1;
  endtask

  initial begin
    int got;
    int n;
    int k;
    logic [31:0] exp_rd;

    clear_inputs();

    // Reset with requests held high.
    bus.wr0_req  = 1'b1;
    bus.wr0_data = 32'h11;
    bus.rd_req   = 1'b1;
    tick();
    tick();
    check("rst_wr_en", bus.fifo_wr_en, 0);
    check("rst_rd_en", bus.fifo_rd_en, 0);
    check("rst_data_in", bus.fifo_data_in, 0);
    check("rst_gnts", {bus.wr0_gnt, bus.wr1_gnt, bus.rd_gnt}, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_occ", bus.occupancy, 0);
    check("rst_sync_err", bus.sync_err, 0);
    rstN = 1'b1;
    #1;
    check("rel_wr_en", bus.fifo_wr_en, 0);
    tick();
    check("first_wr_en", bus.fifo_wr_en, 1);
    check("first_gnt0", bus.wr0_gnt, 1);
    check("first_data", bus.fifo_data_in, 32'h11);
    check("first_rd_en", bus.fifo_rd_en, 0);

    // Fill to depth, then a fifth write is never granted.
    reset_dut();
    bus.wr0_req = 1'b1;
    for (int i = 0; i < D; i++) begin
      bus.wr0_data = 32'hA0 + i;
      got = 0;
      for (int t = 0; t < 8 && got == 0; t++) begin
        tick();
        if (bus.wr0_gnt) got = 1;
      end
      check("fill_gnt", got, 1);
      check("fill_data", bus.fifo_data_in, 32'hA0 + i);
    end
    bus.wr0_data = 32'hA4;
    n = 0;
    repeat (6) begin
      tick();
      n += int'(bus.fifo_wr_en) + int'(bus.wr0_gnt);
    end
    check("full_no_wr", n, 0);
    check("full_occ", bus.occupancy, D);
    check("full_flag", bus.fifo_full, 1);
    check("full_sync", bus.sync_err, 0);

    // Both writers held: round-robin 0,1,0,1 back to back.
    reset_dut();
    bus.wr0_req  = 1'b1;
    bus.wr0_data = 32'hB0;
    bus.wr1_req  = 1'b1;
    bus.wr1_data = 32'hC1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_wr_en", bus.fifo_wr_en, 1);
      check("rr_gnt0", bus.wr0_gnt, (i % 2 == 0) ? 1 : 0);
      check("rr_gnt1", bus.wr1_gnt, (i % 2 == 1) ? 1 : 0);
      check("rr_data", bus.fifo_data_in, (i % 2 == 0) ? 32'hB0 : 32'hC1);
    end
    clear_inputs();
    tick();
    check("rr_occ", bus.occupancy, 4);

    // Two entries preloaded, writer and reader held: strict alternation.
    reset_dut();
    bus.wr0_req  = 1'b1;
    bus.wr0_data = 32'h10;
    tick();
    check("pre_gnt_a", bus.wr0_gnt, 1);
    bus.wr0_data = 32'h20;
    tick();
    tick();
    check("pre_gnt_b", bus.wr0_gnt, 1);
    bus.wr0_data = 32'h30;
    bus.rd_req   = 1'b1;
    k = 0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      check("alt_wr_en", bus.fifo_wr_en, (j % 2 == 0) ? 1 : 0);
      check("alt_rd_en", bus.fifo_rd_en, (j % 2 == 1) ? 1 : 0);
      if (bus.rd_valid) begin
        exp_rd = (k == 0) ? 32'h10 : (k == 1) ? 32'h20 : 32'h30;
        check("alt_rd_data", bus.rd_data, exp_rd);
        k++;
      end
    end
    check("alt_reads", k, 4);
    clear_inputs();
    tick();
    tick();
    check("alt_occ", bus.occupancy, 2);

    // Read on empty is held off; then one write and one read of 0x5A.
    reset_dut();
    bus.rd_req = 1'b1;
    n = 0;
    repeat (4) begin
      tick();
      n += int'(bus.rd_gnt) + int'(bus.fifo_rd_en);
    end
    check("empty_no_rd", n, 0);
    bus.wr0_req  = 1'b1;
    bus.wr0_data = 32'h5A;
    tick();
    check("one_gnt0", bus.wr0_gnt, 1);
    bus.wr0_req = 1'b0;
    tick();
    check("one_idle", bus.rd_gnt, 0);
    tick();
    check("one_rd_gnt", bus.rd_gnt, 1);
    check("one_rd_en", bus.fifo_rd_en, 1);
    bus.rd_req = 1'b0;
    tick();
    check("one_valid", bus.rd_valid, 1);
    check("one_data", bus.rd_data, 32'h5A);
    check("one_occ", bus.occupancy, 0);
    tick();
    check("one_valid_off", bus.rd_valid, 0);
    check("one_data_hold", bus.rd_data, 32'h5A);

    // Flag disagreement sets the sticky sync_err.
    reset_dut();
    bus.wr0_req  = 1'b1;
    bus.wr0_data = 32'h77;
    tick();
    bus.wr0_req = 1'b0;
    tick();
    check("se_occ", bus.occupancy, 1);
    check("se_clean", bus.sync_err, 0);
    force_full = 1'b1;
    tick();
    check("se_set", bus.sync_err, 1);
    force_full = 1'b0;
    repeat (3) tick();
    check("se_sticky", bus.sync_err, 1);
    rstN = 1'b0;
    #1;
    check("se_rst", bus.sync_err, 0);
    check("se_rst_occ", bus.occupancy, 0);
    rstN = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_access_ctrl.md
Name: fifo_access_ctrl

Overview:
Controller that shares one single-port-access FIFO between two write requesters (port 0, port 1) and one read requester. It sequences the FIFO's wr_en/rd_en so that write and read are never asserted together, never reads when empty, and never writes when full. It drives the FIFO's data_in, and holds data_in and both enables at zero during reset. It sits between the client logic and the FIFO instance, so the FIFO-side protocol checks always hold.

Parameters:
FIFO_WIDTH, 32, data width of the FIFO and of all client data ports
FIFO_DEPTH, 16, FIFO entry count; the occupancy counter range is 0..FIFO_DEPTH
CNT_W, $clog2(FIFO_DEPTH+1), occupancy counter width

Ports:
clk  in  1  clock, rising edge
rstN  in  1  asynchronous active-low reset
wr0_req  in  1  port 0 write request; level, held until granted
wr0_data  in  FIFO_WIDTH  port 0 write data; stable while wr0_req=1
wr0_gnt  out  1  port 0 write accepted this cycle (1-cycle pulse)
wr1_req  in  1  port 1 write request
wr1_data  in  FIFO_WIDTH  port 1 write data
wr1_gnt  out  1  port 1 write accepted this cycle
rd_req  in  1  read request; level, held until granted
rd_gnt  out  1  read issued this cycle (1-cycle pulse)
rd_valid  out  1  rd_data valid; 1 cycle after rd_gnt
rd_data  out  FIFO_WIDTH  read data returned to the reader
fifo_wr_en  out  1  FIFO write enable
fifo_rd_en  out  1  FIFO read enable
fifo_data_in  out  FIFO_WIDTH  FIFO write data
fifo_data_out  in  FIFO_WIDTH  FIFO read data; registered, valid 1 cycle after fifo_rd_en
fifo_empty  in  1  FIFO empty flag
fifo_full  in  1  FIFO full flag
occupancy  out  CNT_W  controller-tracked entry count
sync_err  out  1  sticky: tracked count disagrees with FIFO flags

Behaviour:
- Reset (rstN=0, asynchronous): all outputs 0. fifo_data_in=0. state=IDLE. rr_ptr=0 (port 0 has priority). last_op=RD. occupancy=0. sync_err=0.
- All outputs are registered. The decision uses current-cycle inputs. The resulting op appears on the next cycle.
- FSM states: IDLE (no op), WR (fifo_wr_en=1 this cycle), RD (fifo_rd_en=1 this cycle). The next state is chosen from any state each cycle:
  - wr_ok = (wr0_req|wr1_req) & !fifo_full & (occupancy_next < FIFO_DEPTH)
  - rd_ok = rd_req & !fifo_empty & (occupancy_next > 0) & !(state==RD & rd_gnt_pending)
  - wr_ok & rd_ok: choose opposite of last_op (strict alternation).
  - Only wr_ok: WR. Only rd_ok: RD. Neither: IDLE.
- occupancy_next is the counter value after the current-cycle op. This prevents back-to-back over/underflow before the FIFO flags update.
- A granted requester must see its gnt before a second op for it is issued. The request is consumed on the gnt cycle; a requester that holds req high after gnt is requesting again.
- Write arbitration: if both wr0_req and wr1_req are high, grant the port at rr_ptr, then rr_ptr flips to the other port. If only one is high, grant it; rr_ptr becomes the port not granted.
- WR cycle: fifo_wr_en=1. fifo_data_in=data of the granted port (sampled at decision). The matching wrX_gnt=1. Otherwise fifo_data_in=0.
- RD cycle: fifo_rd_en=1 and rd_gnt=1. Next cycle: rd_valid=1 and rd_data=fifo_data_out. rd_data holds its last value when rd_valid=0.
- fifo_wr_en & fifo_rd_en is never 1 in the same cycle, under any input combination.
- occupancy: +1 on WR, -1 on RD. It saturates and never wraps.
- sync_err is set (sticky until reset) when either condition holds one cycle after an op:
  - (occupancy==FIFO_DEPTH) != fifo_full
  - (occupancy==0) != fifo_empty
- Reset mid-operation: a pending rd_valid is dropped. Grants and enables clear immediately, asynchronously.

Test Plan:
- Reset with wr0_req=1, rd_req=1 held high -> fifo_wr_en=0, fifo_rd_en=0, fifo_data_in=0, all gnts=0 while rstN=0; first op at the second rising edge after release.
- DEPTH=4, wr0_req held with data 0xA0..0xA3, then a 5th -> four WR cycles with wr0_gnt pulses, occupancy=4, fifo_full=1; 5th write never granted, fifo_wr_en stays 0.
- wr0_req and wr1_req both held, FIFO empty -> grants alternate 0,1,0,1; fifo_data_in alternates wr0_data/wr1_data.
- FIFO holding 2 entries, wr0_req and rd_req both held -> WR/RD alternate each cycle; fifo_wr_en & fifo_rd_en never both 1.
- rd_req on empty FIFO -> no rd_gnt. Then one write of 0x5A, then read -> rd_gnt, next cycle rd_valid=1 with rd_data=0x5A, occupancy back to 0.
- Force fifo_full=1 while occupancy=1 -> sync_err=1 next cycle; it stays 1 until rstN=0.
